// File: rtl/lock_cmd_sequencer.sv
// Initiator for the smart-lock remote interface: issues lock/unlock pulses, confirms them
// against lock_state feedback, retries on timeout and issues an automatic re-lock.
module lock_cmd_sequencer #(
    parameter int PULSE_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES   = 16,
    parameter int MAX_RETRIES      = 2,
    parameter int AUTO_LOCK_CYCLES = 1000,
    parameter int CNT_W            = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic       req_op,
    output logic       req_ready,
    input  logic       auto_lock_en,
    input  logic       lock_state,
    output logic       remote_unlock,
    output logic       remote_lock,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       cmd_auto,
    output logic [2:0] attempts
);

    typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] AUTO_LAST  =
        CNT_W'((AUTO_LOCK_CYCLES > 0) ? AUTO_LOCK_CYCLES - 1 : 0);
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);
    localparam bit               AUTO_ON     = (AUTO_LOCK_CYCLES != 0);

    state_t            state, state_n;
    logic              target, target_n;
    logic              cmd_auto_n;
    logic [3:0]        attempt_cnt, attempt_cnt_n;
    logic [CNT_W-1:0]  pulse_cnt, pulse_cnt_n;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_n;
    logic [CNT_W-1:0]  auto_cnt, auto_cnt_n;
    logic              done_n, error_n;
    logic              auto_cond, auto_fire, ext_accept, accept_tgt;

    // The auto-lock fires in the last qualifying idle cycle, so it is an accept of its own
    // and masks req_ready in that cycle.
    assign auto_cond  = AUTO_ON && (state == IDLE) && auto_lock_en && lock_state;
    assign auto_fire  = auto_cond && (auto_cnt == AUTO_LAST);
    assign req_ready  = (state == IDLE) && !auto_fire;
    assign ext_accept = req_valid && req_ready;
    assign accept_tgt = ext_accept ? req_op : 1'b0;
    assign busy       = (state != IDLE);
    assign attempts   = attempt_cnt[3] ? 3'd7 : attempt_cnt[2:0];

    always_comb begin
        state_n       = state;
        target_n      = target;
        cmd_auto_n    = cmd_auto;
        attempt_cnt_n = attempt_cnt;
        pulse_cnt_n   = pulse_cnt;
        wait_cnt_n    = wait_cnt;
        auto_cnt_n    = '0;
        done_n        = 1'b0;
        error_n       = 1'b0;
        case (state)
            IDLE: begin
                if (ext_accept || auto_fire) begin
                    target_n      = accept_tgt;
                    cmd_auto_n    = auto_fire;
                    attempt_cnt_n = 4'd0;
                    if (lock_state == accept_tgt) begin
                        done_n = 1'b1;
                    end else begin
                        state_n       = PULSE;
                        attempt_cnt_n = 4'd1;
                        pulse_cnt_n   = CNT_W'(1);
                    end
                end else if (auto_cond) begin
                    auto_cnt_n = auto_cnt + CNT_W'(1);
                end
            end
            PULSE: begin
                if (pulse_cnt == PULSE_LAST) begin
                    state_n    = WAIT;
                    wait_cnt_n = CNT_W'(1);
                end else begin
                    pulse_cnt_n = pulse_cnt + CNT_W'(1);
                end
            end
            WAIT: begin
                // A match on the timeout cycle itself still counts as success.
                if (lock_state == target) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    if (attempt_cnt <= RETRY_LIMIT) begin
                        state_n       = PULSE;
                        attempt_cnt_n = attempt_cnt + 4'd1;
                        pulse_cnt_n   = CNT_W'(1);
                    end else begin
                        error_n = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    wait_cnt_n = wait_cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            target        <= 1'b0;
            cmd_auto      <= 1'b0;
            attempt_cnt   <= 4'd0;
            pulse_cnt     <= '0;
            wait_cnt      <= '0;
            auto_cnt      <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            remote_unlock <= 1'b0;
            remote_lock   <= 1'b0;
        end else begin
            state         <= state_n;
            target        <= target_n;
            cmd_auto      <= cmd_auto_n;
            attempt_cnt   <= attempt_cnt_n;
            pulse_cnt     <= pulse_cnt_n;
            wait_cnt      <= wait_cnt_n;
            auto_cnt      <= auto_cnt_n;
            done          <= done_n;
            error         <= error_n;
            remote_unlock <= (state_n == PULSE) && target_n;
            remote_lock   <= (state_n == PULSE) && !target_n;
        end
    end

endmodule

// File: tb/tb_lock_cmd_sequencer.sv
// Randomized self-checking bench for lock_cmd_sequencer; the bench plays the lock and
// predicts every command's timeline from pulse/timeout/retry arithmetic.
module tb_lock_cmd_sequencer;

    localparam int P    = 4;
    localparam int T    = 16;
    localparam int MR   = 2;
    localparam int AUTO = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_op, req_ready, auto_lock_en, lock_state;
    logic       remote_unlock, remote_lock, busy, done, error, cmd_auto;
    logic [2:0] attempts;

    int vectors = 0;
    int miscompares = 0;

    lock_cmd_sequencer #(
        .PULSE_CYCLES(P), .TIMEOUT_CYCLES(T), .MAX_RETRIES(MR),
        .AUTO_LOCK_CYCLES(AUTO), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
        .req_ready(req_ready), .auto_lock_en(auto_lock_en), .lock_state(lock_state),
        .remote_unlock(remote_unlock), .remote_lock(remote_lock), .busy(busy),
        .done(done), .error(error), .cmd_auto(cmd_auto), .attempts(attempts)
    );

    always #5 clk = ~clk;

    // Present a request for one edge; leaves the bench in cycle 1 after the accept.
    task automatic accept_cmd(input logic tgt, input logic ls, input string tag);
        req_valid  = 1'b1;
        req_op     = tgt;
        lock_state = ls;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s req_ready: got %b expected 1", tag, req_ready);
        end
        @(posedge clk) #1;
        req_valid = 1'b0;
        req_op    = 1'($urandom);
    endtask

    // succ = attempt on which the lock answers (at WAIT count k), 0 = never, -1 = already there.
    task automatic run_command(input logic tgt, input int succ, input int k,
                               input bit glitch, input bit is_auto, input string tag);
        int n_att, endc, off, a;
        logic [8:0] want, got;
        n_att = (succ == 0) ? MR + 1 : (succ < 0 ? 0 : succ);
        endc  = (succ == 0) ? n_att * (P + T) : (succ < 0 ? 0 : (succ - 1) * (P + T) + P + k);
        for (int c = 1; c <= endc + 1; c++) begin
            off = (c - 1) % (P + T);
            a   = (c - 1) / (P + T) + 1;
            if (c <= endc)
                want = {1'b1, (off < P) && tgt, (off < P) && !tgt, 1'b0, 1'b0, is_auto, 3'(a)};
            else
                want = {3'b000, succ != 0, succ == 0, is_auto, 3'(n_att)};
            got = {busy, remote_unlock, remote_lock, done, error, cmd_auto, attempts};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL %s cycle %0d {busy,unl,lck,done,err,auto,att}: got %b expected %b",
                         tag, c, got, want);
            end
            if (c > endc)
                lock_state = (succ != 0) ? tgt : !tgt;
            else if (off < P)
                lock_state = glitch ? 1'($urandom) : !tgt;
            else
                lock_state = (a == succ && off - P + 1 >= k) ? tgt : !tgt;
            if (c <= endc) @(posedge clk) #1;
        end
    endtask

    task automatic expect_quiet(input logic [2:0] att, input string tag);
        @(posedge clk) #1;
        vectors++;
        if ({busy, done, error, remote_unlock, remote_lock, attempts} !== {5'b0, att}) begin
            miscompares++;
            $display("[TB] FAIL %s quiet: got %b expected %b", tag,
                     {busy, done, error, remote_unlock, remote_lock, attempts}, {5'b0, att});
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({req_ready, busy, remote_unlock, remote_lock, done, error, cmd_auto, attempts}
            !== 10'b1000000000) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %b expected 1000000000",
                     {req_ready, busy, remote_unlock, remote_lock, done, error, cmd_auto, attempts});
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
    endtask

    task automatic test_unlock_basic();
        accept_cmd(1'b1, 1'b0, "unlock_basic");
        run_command(1'b1, 1, 3, 1'b0, 1'b0, "unlock_basic");
        expect_quiet(3'd1, "unlock_basic");
    endtask

    task automatic test_already_locked();
        accept_cmd(1'b0, 1'b0, "already_locked");
        run_command(1'b0, -1, 0, 1'b0, 1'b0, "already_locked");
        expect_quiet(3'd0, "already_locked");
    endtask

    task automatic test_retry_exhaust();
        accept_cmd(1'b1, 1'b0, "retry_exhaust");
        run_command(1'b1, 0, 0, 1'b0, 1'b0, "retry_exhaust");
        expect_quiet(3'd3, "retry_exhaust");
    endtask

    task automatic test_timeout_boundary();
        accept_cmd(1'b1, 1'b0, "match_at_timeout_a1");
        run_command(1'b1, 1, T, 1'b0, 1'b0, "match_at_timeout_a1");
        accept_cmd(1'b0, 1'b1, "match_at_timeout_a3");
        run_command(1'b0, 3, T, 1'b0, 1'b0, "match_at_timeout_a3");
        expect_quiet(3'd3, "match_at_timeout_a3");
    endtask

    task automatic test_back_to_back();
        accept_cmd(1'b1, 1'b0, "b2b_first");
        run_command(1'b1, 2, $urandom_range(1, T), 1'b1, 1'b0, "b2b_first");
        accept_cmd(1'b0, 1'b1, "b2b_second");
        run_command(1'b0, 1, $urandom_range(1, T), 1'b1, 1'b0, "b2b_second");
        expect_quiet(3'd1, "b2b_second");
    endtask

    task automatic test_auto_lock();
        int drops[2];
        drops[0] = 10;
        drops[1] = $urandom_range(2, AUTO - 1);
        lock_state = 1'b1;
        req_valid  = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int m = 1; m <= drops[r] + 3; m++) begin
                auto_lock_en = (m < drops[r]);
                #1;
                vectors++;
                if ({req_ready, busy, remote_lock} !== 3'b100) begin
                    miscompares++;
                    $display("[TB] FAIL auto_interrupted round %0d cycle %0d: got %b expected 100",
                             r, m, {req_ready, busy, remote_lock});
                end
                @(posedge clk) #1;
            end
        end
        for (int m = 1; m <= AUTO; m++) begin
            auto_lock_en = 1'b1;
            #1;
            vectors++;
            if ({req_ready, busy, remote_lock} !== {m != AUTO, 2'b00}) begin
                miscompares++;
                $display("[TB] FAIL auto_count cycle %0d: got %b expected %b",
                         m, {req_ready, busy, remote_lock}, {m != AUTO, 2'b00});
            end
            @(posedge clk) #1;
        end
        run_command(1'b0, 1, $urandom_range(1, T), 1'b0, 1'b1, "auto_lock");
        auto_lock_en = 1'b0;
        expect_quiet(3'd1, "auto_lock");
    endtask

    task automatic test_reset_mid_pulse();
        accept_cmd(1'b1, 1'b0, "reset_mid_pulse");
        @(posedge clk) #1;
        vectors++;
        if (remote_unlock !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_pre_pulse: got %b expected 1", remote_unlock);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({remote_unlock, remote_lock, busy, req_ready, done, error, attempts} !== 9'b000100000) begin
            miscompares++;
            $display("[TB] FAIL reset_async: got %b expected 000100000",
                     {remote_unlock, remote_lock, busy, req_ready, done, error, attempts});
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk) #1;
            vectors++;
            if ({remote_unlock, remote_lock, busy, req_ready, done, error} !== 6'b000100) begin
                miscompares++;
                $display("[TB] FAIL reset_after cycle %0d: got %b expected 000100",
                         i, {remote_unlock, remote_lock, busy, req_ready, done, error});
            end
        end
    endtask

    task automatic test_auto_vs_external();
        lock_state = 1'b1;
        for (int m = 1; m <= AUTO; m++) begin
            auto_lock_en = 1'b1;
            if (m == AUTO) begin
                req_valid = 1'b1;
                req_op    = 1'b1;
            end
            if (m < AUTO) @(posedge clk) #1;
        end
        #1;
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL auto_vs_ext ready_at_fire: got %b expected 0", req_ready);
        end
        @(posedge clk) #1;
        run_command(1'b0, 1, $urandom_range(1, T), 1'b0, 1'b1, "auto_vs_ext_auto");
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL auto_vs_ext ready_on_return: got %b expected 1", req_ready);
        end
        @(posedge clk) #1;
        req_valid = 1'b0;
        run_command(1'b1, 1, $urandom_range(1, T), 1'b0, 1'b0, "auto_vs_ext_ext");
        auto_lock_en = 1'b0;
        expect_quiet(3'd1, "auto_vs_ext_ext");
    endtask

    task automatic test_random();
        logic tgt;
        int succ;
        for (int i = 0; i < 30; i++) begin
            tgt = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                accept_cmd(tgt, tgt, "random_match");
                run_command(tgt, -1, 0, 1'b1, 1'b0, "random_match");
                expect_quiet(3'd0, "random_match");
            end else begin
                succ = $urandom_range(0, MR + 1);
                accept_cmd(tgt, !tgt, "random_cmd");
                run_command(tgt, succ, $urandom_range(1, T), 1'b1, 1'b0, "random_cmd");
                expect_quiet(3'((succ == 0) ? MR + 1 : succ), "random_cmd");
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_op       = 1'b0;
        auto_lock_en = 1'b0;
        lock_state   = 1'b0;
        test_reset();
        test_unlock_basic();
        test_already_locked();
        test_retry_exhaust();
        test_timeout_boundary();
        test_back_to_back();
        test_auto_lock();
        test_reset_mid_pulse();
        test_auto_vs_external();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
